// File: rtl/dvsd_param_updown_counter.sv
// dvsd_param_updown_counter: bounded up/down counter with load, wrap/saturate limits,
// a registered terminal-count pulse and a saturating limit-event counter.
module dvsd_param_updown_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int SAT_MODE  = 0,
    parameter int RESET_VAL = 0,
    parameter int EVT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             updown,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_evt,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic [EVT_W-1:0] evt_cnt,
    output logic             ovf_sticky
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);
    localparam bit               SAT  = SAT_MODE != 0;

    logic             at_max, at_min, evt;
    logic [WIDTH-1:0] up_v, dn_v, nxt;

    always_comb begin
        at_max = out == MAXV;
        at_min = out == '0;
        evt    = !load && en && (updown ? at_max : at_min);
        up_v   = at_max ? (SAT ? MAXV : '0) : out + 1'b1;
        dn_v   = at_min ? (SAT ? '0 : MAXV) : out - 1'b1;
        nxt    = load ? (load_val > MAXV ? MAXV : load_val) : !en ? out : updown ? up_v : dn_v;
    end

    // clr_evt wins over a same-cycle event; tc is unaffected by it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out        <= RSTV;
            tc         <= 1'b0;
            evt_cnt    <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            out        <= nxt;
            tc         <= evt;
            evt_cnt    <= clr_evt ? '0 : (evt && evt_cnt != '1) ? evt_cnt + 1'b1 : evt_cnt;
            ovf_sticky <= !clr_evt && (ovf_sticky || evt);
        end
    end
endmodule
